// File: rtl/micro_pkg.sv
// Shared decode constants: micro-ROM start addresses, RV32 opcode/funct fields,
// decoder state and immediate-format enums, and the per-instruction decode table.
package micro_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_SHIFT} state_t;
  typedef enum logic [2:0] {FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_t;

  localparam logic [4:0] ADDR_LW     = 5'd0;
  localparam logic [4:0] ADDR_SW     = 5'd2;
  localparam logic [4:0] ADDR_ADD    = 5'd4;
  localparam logic [4:0] ADDR_AND    = 5'd5;
  localparam logic [4:0] ADDR_XOR    = 5'd6;
  localparam logic [4:0] ADDR_OR     = 5'd7;
  localparam logic [4:0] ADDR_ADDI   = 5'd8;
  localparam logic [4:0] ADDR_ANDI   = 5'd9;
  localparam logic [4:0] ADDR_XORI   = 5'd10;
  localparam logic [4:0] ADDR_ORI    = 5'd11;
  localparam logic [4:0] ADDR_LUI    = 5'd12;
  localparam logic [4:0] ADDR_AUIPC  = 5'd13;
  localparam logic [4:0] ADDR_JAL    = 5'd14;
  localparam logic [4:0] ADDR_JALR   = 5'd16;
  localparam logic [4:0] ADDR_IDLE   = 5'd18;
  localparam logic [4:0] ADDR_BEQ    = 5'd19;
  localparam logic [4:0] ADDR_BLTU   = 5'd21;
  localparam logic [4:0] ADDR_SUB    = 5'd24;
  localparam logic [4:0] ADDR_SLLI   = 5'd27;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic      legal;
    logic [4:0] addr;
    imm_fmt_t  fmt;
    logic      swap;
    logic      inv;
    logic      shift;
  } dec_t;

  function automatic dec_t decode_inst(input logic [31:0] inst);
    dec_t       d;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = inst[6:0];
    f3 = inst[14:12];
    f7 = inst[31:25];
    d = '0;
    d.addr = ADDR_IDLE;
    d.fmt  = FMT_NONE;
    case (op)
      OP_LOAD:  if (f3 == F3_LW) begin d.legal = 1'b1; d.addr = ADDR_LW; d.fmt = FMT_I; end
      OP_STORE: if (f3 == F3_LW) begin d.legal = 1'b1; d.addr = ADDR_SW; d.fmt = FMT_S; end
      OP_REG: begin
        if (f7 == F7_BASE) begin
          d.legal = 1'b1;
          case (f3)
            F3_ADD:  d.addr = ADDR_ADD;
            F3_AND:  d.addr = ADDR_AND;
            F3_XOR:  d.addr = ADDR_XOR;
            F3_OR:   d.addr = ADDR_OR;
            default: begin d.legal = 1'b0; d.addr = ADDR_IDLE; end
          endcase
        end else if (f7 == F7_ALT && f3 == F3_ADD) begin
          d.legal = 1'b1;
          d.addr  = ADDR_SUB;
        end
      end
      OP_IMM: begin
        d.fmt   = FMT_I;
        d.legal = 1'b1;
        case (f3)
          F3_ADD: d.addr = ADDR_ADDI;
          F3_AND: d.addr = ADDR_ANDI;
          F3_XOR: d.addr = ADDR_XORI;
          F3_OR:  d.addr = ADDR_ORI;
          // A zero shift amount degenerates to a plain register copy via ADDI.
          F3_SLL: begin
            d.legal = (f7 == F7_BASE);
            d.shift = (f7 == F7_BASE) && (inst[24:20] != 5'd0);
            d.addr  = (f7 != F7_BASE) ? ADDR_IDLE :
                      (inst[24:20] != 5'd0) ? ADDR_SLLI : ADDR_ADDI;
          end
          default: begin d.legal = 1'b0; d.fmt = FMT_NONE; end
        endcase
      end
      OP_LUI:   begin d.legal = 1'b1; d.addr = ADDR_LUI;   d.fmt = FMT_U; end
      OP_AUIPC: begin d.legal = 1'b1; d.addr = ADDR_AUIPC; d.fmt = FMT_U; end
      OP_JAL:   begin d.legal = 1'b1; d.addr = ADDR_JAL;   d.fmt = FMT_J; end
      OP_JALR:  if (f3 == F3_ADD) begin d.legal = 1'b1; d.addr = ADDR_JALR; d.fmt = FMT_I; end
      OP_BRANCH: begin
        d.fmt = FMT_B;
        case (f3)
          F3_BEQ:  begin d.legal = 1'b1; d.addr = ADDR_BEQ;  d.inv = 1'b1; end
          F3_BNE:  begin d.legal = 1'b1; d.addr = ADDR_BEQ;  end
          F3_BLTU: begin d.legal = 1'b1; d.addr = ADDR_BLTU; d.swap = 1'b1; end
          F3_BGEU: begin d.legal = 1'b1; d.addr = ADDR_BLTU; d.swap = 1'b1; d.inv = 1'b1; end
          default: d.fmt = FMT_NONE;
        endcase
      end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32 immediate extraction; format is chosen by the decoder.
module imm_gen
  import micro_pkg::*;
(
  input  logic [31:0] i_inst,
  input  imm_fmt_t    i_fmt,
  output logic [31:0] o_imm
);

  always_comb begin
    o_imm = '0;
    case (i_fmt)
      FMT_I:   o_imm = {{20{i_inst[31]}}, i_inst[31:20]};
      FMT_S:   o_imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      FMT_B:   o_imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
      FMT_U:   o_imm = {i_inst[31:12], 12'd0};
      FMT_J:   o_imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/inst_decode.sv
// Instruction decode stage: latches one RV32 instruction, hands a micro-ROM start
// address to the micro-sequencer and repeats SLLI as N single-bit shift passes.
module inst_decode
  import micro_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid_inst,
  input  logic [31:0] if_inst,
  output logic        if_ready,
  input  logic        rf_valid_inst_out,
  output logic [4:0]  decode_addr,
  output logic        id_rf_valid_inst,
  output logic [4:0]  rs1_idx,
  output logic [4:0]  rs2_idx,
  output logic [4:0]  rd_idx,
  output logic [31:0] imm,
  output logic        swap_operands,
  output logic        br_invert,
  output logic        illegal_inst
);

  state_t      r_state;
  logic [4:0]  r_cnt;
  dec_t        w_dec;
  logic [31:0] w_imm;
  logic        w_done;
  logic        w_transfer;

  assign w_dec = decode_inst(if_inst);

  imm_gen u_imm_gen (
    .i_inst (if_inst),
    .i_fmt  (w_dec.fmt),
    .o_imm  (w_imm)
  );

  // The last pending pass frees the slot in the same cycle, so the next word can issue without a bubble.
  assign w_done     = rf_valid_inst_out &
                      ((r_state == ST_EXEC) | ((r_state == ST_SHIFT) & (r_cnt == 5'd1)));
  assign if_ready   = ~rst & ((r_state == ST_IDLE) | w_done);
  assign w_transfer = if_valid_inst & if_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_cnt            <= 5'd0;
      id_rf_valid_inst <= 1'b0;
      decode_addr      <= ADDR_IDLE;
      rs1_idx          <= 5'd0;
      rs2_idx          <= 5'd0;
      rd_idx           <= 5'd0;
      imm              <= 32'd0;
      swap_operands    <= 1'b0;
      br_invert        <= 1'b0;
      illegal_inst     <= 1'b0;
    end else begin
      illegal_inst <= 1'b0;
      if (w_transfer) begin
        if (w_dec.legal) begin
          r_state          <= w_dec.shift ? ST_SHIFT : ST_EXEC;
          r_cnt            <= w_dec.shift ? if_inst[24:20] : 5'd0;
          id_rf_valid_inst <= 1'b1;
          decode_addr      <= w_dec.addr;
          rs1_idx          <= if_inst[19:15];
          rs2_idx          <= if_inst[24:20];
          rd_idx           <= if_inst[11:7];
          imm              <= w_imm;
          swap_operands    <= w_dec.swap;
          br_invert        <= w_dec.inv;
        end else begin
          r_state          <= ST_IDLE;
          r_cnt            <= 5'd0;
          id_rf_valid_inst <= 1'b0;
          decode_addr      <= ADDR_IDLE;
          illegal_inst     <= 1'b1;
        end
      end else if (w_done) begin
        r_state          <= ST_IDLE;
        r_cnt            <= 5'd0;
        id_rf_valid_inst <= 1'b0;
        decode_addr      <= ADDR_IDLE;
      end else if ((r_state == ST_SHIFT) && rf_valid_inst_out) begin
        // Later shift passes operate on the partially shifted destination.
        r_cnt   <= r_cnt - 5'd1;
        rs1_idx <= rd_idx;
      end
    end
  end

endmodule

// File: tb/tb_inst_decode.sv
// Bench for inst_decode: directed scenarios then random traffic, checked against a
// table-driven reference model that counts outstanding micro-sequence passes.
module tb_inst_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid_inst = 1'b0;
  logic [31:0] if_inst = '0;
  logic        if_ready;
  logic        rf_valid_inst_out = 1'b0;
  logic [4:0]  decode_addr;
  logic        id_rf_valid_inst;
  logic [4:0]  rs1_idx, rs2_idx, rd_idx;
  logic [31:0] imm;
  logic        swap_operands, br_invert, illegal_inst;

  inst_decode dut (
    .clk               (clk),
    .rst               (rst),
    .if_valid_inst     (if_valid_inst),
    .if_inst           (if_inst),
    .if_ready          (if_ready),
    .rf_valid_inst_out (rf_valid_inst_out),
    .decode_addr       (decode_addr),
    .id_rf_valid_inst  (id_rf_valid_inst),
    .rs1_idx           (rs1_idx),
    .rs2_idx           (rs2_idx),
    .rd_idx            (rd_idx),
    .imm               (imm),
    .swap_operands     (swap_operands),
    .br_invert         (br_invert),
    .illegal_inst      (illegal_inst)
  );

  always #5 clk = ~clk;

  localparam int F_N = 0, F_I = 1, F_S = 2, F_B = 3, F_U = 4, F_J = 5;
  localparam int SLLI_ENTRY = 12;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    int          addr;
    int          fmt;
    bit          swap;
    bit          inv;
  } entry_t;

  entry_t tbl [20] = '{
    '{32'hFE00707F, 32'h00000033,  4, F_N, 1'b0, 1'b0},  // ADD
    '{32'hFE00707F, 32'h40000033, 24, F_N, 1'b0, 1'b0},  // SUB
    '{32'hFE00707F, 32'h00007033,  5, F_N, 1'b0, 1'b0},  // AND
    '{32'hFE00707F, 32'h00004033,  6, F_N, 1'b0, 1'b0},  // XOR
    '{32'hFE00707F, 32'h00006033,  7, F_N, 1'b0, 1'b0},  // OR
    '{32'h0000707F, 32'h00002003,  0, F_I, 1'b0, 1'b0},  // LW
    '{32'h0000707F, 32'h00000013,  8, F_I, 1'b0, 1'b0},  // ADDI
    '{32'h0000707F, 32'h00007013,  9, F_I, 1'b0, 1'b0},  // ANDI
    '{32'h0000707F, 32'h00004013, 10, F_I, 1'b0, 1'b0},  // XORI
    '{32'h0000707F, 32'h00006013, 11, F_I, 1'b0, 1'b0},  // ORI
    '{32'h0000707F, 32'h00000067, 16, F_I, 1'b0, 1'b0},  // JALR
    '{32'h0000707F, 32'h00002023,  2, F_S, 1'b0, 1'b0},  // SW
    '{32'hFE00707F, 32'h00001013, 27, F_I, 1'b0, 1'b0},  // SLLI
    '{32'h0000007F, 32'h00000037, 12, F_U, 1'b0, 1'b0},  // LUI
    '{32'h0000007F, 32'h00000017, 13, F_U, 1'b0, 1'b0},  // AUIPC
    '{32'h0000007F, 32'h0000006F, 14, F_J, 1'b0, 1'b0},  // JAL
    '{32'h0000707F, 32'h00000063, 19, F_B, 1'b0, 1'b1},  // BEQ
    '{32'h0000707F, 32'h00001063, 19, F_B, 1'b0, 1'b0},  // BNE
    '{32'h0000707F, 32'h00006063, 21, F_B, 1'b1, 1'b0},  // BLTU
    '{32'h0000707F, 32'h00007063, 21, F_B, 1'b1, 1'b1}   // BGEU
  };

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: number of micro-sequence passes still owed for the held instruction.
  int          m_passes = 0;
  logic [4:0]  m_addr = 5'd18;
  logic [4:0]  m_rs1 = '0, m_rs2 = '0, m_rd = '0;
  logic [31:0] m_imm = '0;
  bit          m_swap = 0, m_inv = 0, m_illegal = 0;
  bit          m_known = 0, m_imm_chk = 0;

  function automatic logic [31:0] ref_imm(input logic [31:0] x, input int fmt);
    logic [31:0] s;
    s = x[31] ? 32'hFFFFFFFF : 32'h0;
    case (fmt)
      F_I: return $signed(x) >>> 20;
      F_S: return (s << 12) | (32'(x[31:25]) << 5) | 32'(x[11:7]);
      F_B: return (s << 12) | (32'(x[7]) << 11) | (32'(x[30:25]) << 5) | (32'(x[11:8]) << 1);
      F_U: return x & 32'hFFFFF000;
      F_J: return (s << 20) | (32'(x[19:12]) << 12) | (32'(x[20]) << 11) | (32'(x[30:21]) << 1);
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_accept(input logic [31:0] x);
    int hit;
    hit = -1;
    for (int e = 0; e < 20; e++)
      if (hit < 0 && ((x & tbl[e].mask) == tbl[e].match)) hit = e;
    if (hit < 0) begin
      m_illegal = 1;
      m_known   = 0;
      return;
    end
    m_addr    = 5'(tbl[hit].addr);
    m_passes  = 1;
    if (hit == SLLI_ENTRY) begin
      if (x[24:20] == 5'd0) m_addr = 5'd8;
      else m_passes = int'(x[24:20]);
    end
    m_rs1     = x[19:15];
    m_rs2     = x[24:20];
    m_rd      = x[11:7];
    m_imm     = ref_imm(x, tbl[hit].fmt);
    m_imm_chk = (tbl[hit].fmt != F_N);
    m_swap    = tbl[hit].swap;
    m_inv     = tbl[hit].inv;
    m_known   = 1;
  endtask

  task automatic step(input bit rst_i, input bit v_i, input logic [31:0] inst_i,
                      input bit rfv_i, output bit acc);
    bit exp_ready;
    @(negedge clk);
    rst               = rst_i;
    if_valid_inst     = v_i;
    if_inst           = inst_i;
    rf_valid_inst_out = rfv_i;
    #1;
    exp_ready = !rst_i && ((m_passes == 0) || (rfv_i && m_passes == 1));
    check("if_ready", 32'(if_ready), 32'(exp_ready));
    acc = v_i && exp_ready;
    if (rst_i) begin
      m_passes = 0; m_addr = 5'd18; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_imm = '0;
      m_swap = 0; m_inv = 0; m_illegal = 0; m_known = 1; m_imm_chk = 1;
    end else begin
      m_illegal = 0;
      if (rfv_i && m_passes > 0) begin
        m_passes--;
        if (m_passes > 0) m_rs1 = m_rd;
        else m_known = 0;
      end
      if (acc) begin
        $display("accept inst=%h t=%0t", inst_i, $time);
        model_accept(inst_i);
      end
    end
    @(posedge clk);
    #1;
    check("valid", 32'(id_rf_valid_inst), 32'(m_passes > 0));
    check("decode_addr", 32'(decode_addr), (m_passes > 0) ? 32'(m_addr) : 32'd18);
    check("illegal", 32'(illegal_inst), 32'(m_illegal));
    if (m_known) begin
      check("rs1_idx", 32'(rs1_idx), 32'(m_rs1));
      check("rs2_idx", 32'(rs2_idx), 32'(m_rs2));
      check("rd_idx", 32'(rd_idx), 32'(m_rd));
      check("swap", 32'(swap_operands), 32'(m_swap));
      check("br_invert", 32'(br_invert), 32'(m_inv));
      if (m_imm_chk) check("imm", imm, m_imm);
    end
  endtask

  initial begin
    bit          acc, hold, cur_v, r;
    logic [31:0] cur_i;
    int          e;

    // Reset, plus reset winning over a simultaneous transfer.
    step(1, 0, 32'h0, 0, acc);
    step(1, 1, 32'h002081B3, 1, acc);
    // ADD x3,x1,x2 then completion.
    step(0, 1, 32'h002081B3, 0, acc);
    check("add_addr", 32'(decode_addr), 32'd4);
    step(0, 0, 32'h0, 0, acc);
    step(0, 0, 32'h0, 1, acc);
    // rf_valid_inst_out while idle is ignored.
    step(0, 0, 32'h0, 1, acc);
    // SLLI x5,x5,3: three passes.
    step(0, 1, 32'h00329293, 0, acc);
    step(0, 0, 32'h0, 1, acc);
    step(0, 0, 32'h0, 0, acc);
    step(0, 0, 32'h0, 1, acc);
    check("slli_hold", 32'(id_rf_valid_inst), 32'd1);
    step(0, 0, 32'h0, 1, acc);
    // SLLI shamt=0 issues as ADDI with imm 0.
    step(0, 1, 32'h00009293, 0, acc);
    step(0, 0, 32'h0, 1, acc);
    // BGEU x1,x2,-8.
    step(0, 1, 32'hFE20FCE3, 0, acc);
    check("bgeu_imm", imm, 32'hFFFFFFF8);
    check("bgeu_addr", 32'(decode_addr), 32'd21);
    step(0, 0, 32'h0, 1, acc);
    // LW then XORI back-to-back with fetch holding the word.
    step(0, 1, 32'h00012083, 0, acc);
    step(0, 1, 32'h00524193, 0, acc);
    step(0, 1, 32'h00524193, 1, acc);
    check("xori_accept", 32'(acc), 32'd1);
    check("xori_addr", 32'(decode_addr), 32'd10);
    step(0, 0, 32'h0, 1, acc);
    // All-ones word is illegal.
    step(0, 1, 32'hFFFFFFFF, 0, acc);
    step(0, 0, 32'h0, 0, acc);
    // Reset during the second pass of SLLI shamt=4, then a fresh instruction.
    step(0, 1, 32'h00439313, 0, acc);
    step(0, 0, 32'h0, 1, acc);
    step(1, 0, 32'h0, 1, acc);
    step(0, 1, 32'h002081B3, 0, acc);
    step(0, 0, 32'h0, 1, acc);

    // Random traffic; an unconsumed fetch word is held until accepted.
    hold  = 0;
    cur_v = 0;
    cur_i = '0;
    for (int k = 0; k < 1500; k++) begin
      if (!hold) begin
        cur_v = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 9) == 0) cur_i = $urandom;
        else begin
          e = int'($urandom_range(0, 19));
          cur_i = ($urandom & ~tbl[e].mask) | tbl[e].match;
        end
      end
      r = ($urandom_range(0, 99) == 0);
      step(r, cur_v, cur_i, 1'($urandom_range(0, 1)), acc);
      hold = cur_v && !acc;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
